// File: rtl/dvsd_div_pkg.sv
// ---------------------------------------------------------------------------
// dvsd_div_pkg
//   Shared definitions for the 16-by-8 iterative restoring divider:
//   FSM state encoding, default operand widths and the step-counter width.
// ---------------------------------------------------------------------------
package dvsd_div_pkg;

  // Default dividend/quotient width; also the number of iteration cycles.
  localparam int N_WIDTH = 16;
  // Default divisor/remainder width.
  localparam int D_WIDTH = 8;
  // Step counter must be able to hold the value N_WIDTH.
  localparam int CNT_W   = $clog2(N_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : dvsd_div_pkg

// File: rtl/dvsd_16by8_div_if.sv
// ---------------------------------------------------------------------------
// dvsd_16by8_div_if
//   Operand and result handshake bundle of the divider.
//   Operand side : in_valid, in_ready, m (dividend), b (divisor)
//   Result side  : out_valid, out_ready, q (quotient), r (remainder),
//                  ovf (quotient does not fit D_WIDTH bits), dbz (divide by 0)
//   master : the producer/consumer driving operands and accepting results
//   slave  : the divider itself
// ---------------------------------------------------------------------------
interface dvsd_16by8_div_if #(
  parameter int N_WIDTH = dvsd_div_pkg::N_WIDTH,
  parameter int D_WIDTH = dvsd_div_pkg::D_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [N_WIDTH-1:0] m;
  logic [D_WIDTH-1:0] b;
  logic               out_valid;
  logic               out_ready;
  logic [N_WIDTH-1:0] q;
  logic [D_WIDTH-1:0] r;
  logic               ovf;
  logic               dbz;

  modport master (
    output in_valid, m, b, out_ready,
    input  in_ready, out_valid, q, r, ovf, dbz
  );

  modport slave (
    input  in_valid, m, b, out_ready,
    output in_ready, out_valid, q, r, ovf, dbz
  );

endinterface : dvsd_16by8_div_if

// File: rtl/dvsd_div_step.sv
// ---------------------------------------------------------------------------
// dvsd_div_step
//   One purely combinational restoring-division step.
//   pr_i     : current partial remainder (always < b_i)
//   bit_i    : next dividend bit shifted into the partial remainder
//   b_i      : divisor
//   pr_o     : new partial remainder
//   q_bit_o  : quotient bit produced by this step
// ---------------------------------------------------------------------------
module dvsd_div_step #(
  parameter int D_WIDTH = dvsd_div_pkg::D_WIDTH
) (
  input  logic [D_WIDTH-1:0] pr_i,
  input  logic               bit_i,
  input  logic [D_WIDTH-1:0] b_i,
  output logic [D_WIDTH-1:0] pr_o,
  output logic               q_bit_o
);

  // The shifted remainder needs one extra bit: pr < b means 2*pr+1 can
  // exceed D_WIDTH bits, but never 2*b.
  logic [D_WIDTH:0] trial_s;
  logic [D_WIDTH:0] div_s;

  assign trial_s = {pr_i, bit_i};
  assign div_s   = {1'b0, b_i};

  // Trial subtraction; restore (keep the shifted value) when it would go negative.
  always_comb begin
    pr_o    = trial_s[D_WIDTH-1:0];
    q_bit_o = 1'b0;
    if (trial_s >= div_s) begin
      // Result is < b, so dropping the top bit loses nothing.
      pr_o    = D_WIDTH'(trial_s - div_s);
      q_bit_o = 1'b1;
    end else begin
      pr_o    = trial_s[D_WIDTH-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule : dvsd_div_step

// File: rtl/dvsd_16by8_div.sv
// ---------------------------------------------------------------------------
// dvsd_16by8_div
//   Iterative restoring divider, one quotient bit per clock.
//   m / b -> q, r. Recovers operand a from a product m = a*b of the 8x8
//   multiplier; ovf flags quotients wider than D_WIDTH bits.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset, aborts any operation
//   bus     : slave side of dvsd_16by8_div_if (operand and result handshakes)
//   Latency from the accept edge: N_WIDTH cycles; divide-by-zero results
//   are presented straight from the accept edge. in_ready is high only in
//   IDLE, so the minimum issue interval is N_WIDTH+2 cycles.
//   The interface instance must use the same widths as this module.
// ---------------------------------------------------------------------------
module dvsd_16by8_div #(
  parameter int N_WIDTH = dvsd_div_pkg::N_WIDTH,
  parameter int D_WIDTH = dvsd_div_pkg::D_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  dvsd_16by8_div_if.slave         bus
);

  import dvsd_div_pkg::*;

  localparam int STEP_CW = $clog2(N_WIDTH + 1);

  state_e               state_q, state_d;
  logic [STEP_CW-1:0]   cnt_q,   cnt_d;
  logic [D_WIDTH-1:0]   pr_q,    pr_d;
  logic [N_WIDTH-1:0]   qreg_q,  qreg_d;
  logic [D_WIDTH-1:0]   b_q,     b_d;
  logic [N_WIDTH-1:0]   q_q,     q_d;
  logic [D_WIDTH-1:0]   r_q,     r_d;
  logic                 ovf_q,   ovf_d;
  logic                 dbz_q,   dbz_d;

  logic [D_WIDTH-1:0]   step_pr_s;
  logic                 step_bit_s;
  logic [N_WIDTH-1:0]   new_q_s;

  // The dividend is consumed MSB first out of the quotient shift register
  // while the quotient bits enter at its LSB.
  dvsd_div_step #(
    .D_WIDTH (D_WIDTH)
  ) u_step (
    .pr_i    (pr_q),
    .bit_i   (qreg_q[N_WIDTH-1]),
    .b_i     (b_q),
    .pr_o    (step_pr_s),
    .q_bit_o (step_bit_s)
  );

  assign new_q_s = {qreg_q[N_WIDTH-2:0], step_bit_s};

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    qreg_d  = qreg_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          b_d = bus.b;
          if (bus.b == {D_WIDTH{1'b0}}) begin
            // Nothing to iterate: publish the saturated result at once.
            state_d = S_DONE;
            q_d     = {N_WIDTH{1'b1}};
            r_d     = bus.m[D_WIDTH-1:0];
            ovf_d   = 1'b1;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = STEP_CW'(N_WIDTH);
            pr_d    = {D_WIDTH{1'b0}};
            qreg_d  = bus.m;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUSY: begin
        pr_d   = step_pr_s;
        qreg_d = new_q_s;
        cnt_d  = cnt_q - STEP_CW'(1);
        if (cnt_q == STEP_CW'(1)) begin
          // Result registers change only here, so no partial quotient is
          // ever visible on the outputs.
          state_d = S_DONE;
          q_d     = new_q_s;
          r_d     = step_pr_s;
          ovf_d   = |new_q_s[N_WIDTH-1:D_WIDTH];
          dbz_d   = 1'b0;
        end else begin
          state_d = S_BUSY;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and result registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {STEP_CW{1'b0}};
      pr_q    <= {D_WIDTH{1'b0}};
      qreg_q  <= {N_WIDTH{1'b0}};
      b_q     <= {D_WIDTH{1'b0}};
      q_q     <= {N_WIDTH{1'b0}};
      r_q     <= {D_WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      qreg_q  <= qreg_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags are direct decodes of the state register.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;

endmodule : dvsd_16by8_div
